// File: rtl/acc_core.sv
// -----------------------------------------------------------------------------
// acc_core
//   Fixed-function ten-class scorer. A start request in IDLE clears the ten
//   accumulators, then 64 consecutive cycles each consume one 24-bit word
//   (three 8-bit pixels) from an internal read-only memory. Each accumulator k
//   adds the three pixels weighted by w(p,k) = ((p+k) mod 3) - 1. On the
//   following cycle each score is biased by 10*k, clamped to 0..255 and
//   registered onto the outputs.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rstn           asynchronous reset, ACTIVE HIGH despite its name
//   AccValid_i     start request, only looked at while idle
//   AccReady_o     1 = idle with results held, 0 = run in progress
//   Num0_o..Num9_o unsigned 8-bit class scores, registered
// -----------------------------------------------------------------------------
module acc_core (
  input  logic       clk,
  input  logic       rstn,
  input  logic       AccValid_i,
  output logic       AccReady_o,
  output logic [7:0] Num0_o,
  output logic [7:0] Num1_o,
  output logic [7:0] Num2_o,
  output logic [7:0] Num3_o,
  output logic [7:0] Num4_o,
  output logic [7:0] Num5_o,
  output logic [7:0] Num6_o,
  output logic [7:0] Num7_o,
  output logic [7:0] Num8_o,
  output logic [7:0] Num9_o
);

  localparam int NumClasses = 10;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q;
  logic [5:0]         addr_q;
  logic               last_q;   // set once word 63 has been accumulated
  logic signed [19:0] acc_q  [NumClasses];
  logic signed [19:0] acc_d  [NumClasses];
  logic signed [19:0] biased [NumClasses];
  logic [7:0]         num_q  [NumClasses];
  logic [7:0]         num_d  [NumClasses];
  logic [23:0]        word;

  // Read-only data memory: word a holds pixels 3a, 3a+1, 3a+2 and pixel p
  // has value p, so the contents reduce to a little arithmetic on the address.
  function automatic logic [23:0] rom_word(input logic [5:0] a);
    logic [7:0] base;
    base = {1'b0, a, 1'b0} + {2'b00, a};
    return {base + 8'd2, base + 8'd1, base};
  endfunction

  assign word = rom_word(addr_q);

  // Pixel p = 3a+i, so (p+k) mod 3 == (i+k) mod 3: the weight of each byte
  // lane is a constant per class, and no weight ROM is needed.
  // NOTE: every combinational output is given a default before any
  // conditional update so no path leaves it unassigned (no latches).
  always_comb begin
    for (int k = 0; k < NumClasses; k++) begin
      acc_d[k] = acc_q[k];
      for (int i = 0; i < 3; i++) begin
        case ((i + k) % 3)
          0:       acc_d[k] = acc_d[k] - signed'({12'd0, word[8*i +: 8]});
          2:       acc_d[k] = acc_d[k] + signed'({12'd0, word[8*i +: 8]});
          default: ;
        endcase
      end
    end
  end

  // Bias b(k) = 10*k, then saturate to the unsigned 8-bit output range.
  always_comb begin
    for (int k = 0; k < NumClasses; k++) begin
      biased[k] = acc_q[k] + 20'(10 * k);
      if (biased[k] < 0) begin
        num_d[k] = 8'd0;
      end else if (biased[k] > 20'sd255) begin
        num_d[k] = 8'd255;
      end else begin
        num_d[k] = biased[k][7:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  // NOTE: the accumulator and score arrays are plain flops, not a RAM, so
  // they are cleared by the asynchronous reset like any other register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= 1'b0;
      for (int k = 0; k < NumClasses; k++) begin
        acc_q[k] <= '0;
        num_q[k] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (AccValid_i) begin
            state_q <= BUSY;
            addr_q  <= '0;
            last_q  <= 1'b0;
            for (int k = 0; k < NumClasses; k++) begin
              acc_q[k] <= '0;
            end
          end
        end
        BUSY: begin
          if (!last_q) begin
            for (int k = 0; k < NumClasses; k++) begin
              acc_q[k] <= acc_d[k];
            end
            // The address parks on 63 and only wraps when the run completes.
            if (addr_q == 6'd63) begin
              last_q <= 1'b1;
            end else begin
              addr_q <= addr_q + 6'd1;
            end
          end else begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= 1'b0;
            for (int k = 0; k < NumClasses; k++) begin
              num_q[k] <= num_d[k];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign AccReady_o = (state_q == IDLE);

  assign Num0_o = num_q[0];
  assign Num1_o = num_q[1];
  assign Num2_o = num_q[2];
  assign Num3_o = num_q[3];
  assign Num4_o = num_q[4];
  assign Num5_o = num_q[5];
  assign Num6_o = num_q[6];
  assign Num7_o = num_q[7];
  assign Num8_o = num_q[8];
  assign Num9_o = num_q[9];

endmodule

// File: tb/tb_acc_core.sv
// -----------------------------------------------------------------------------
// tb_acc_core
//   Scoreboard bench for acc_core. A model process accepts start requests the
//   way the block should (idle only, 65-cycle run) and pushes the expected
//   scores into a queue; a monitor pops and compares whenever the DUT returns
//   to ready, and checks every other cycle that ready matches the model and
//   the scores are held.
// -----------------------------------------------------------------------------
module tb_acc_core;

  typedef logic [9:0][7:0] scores_t;

  localparam int RunCycles = 65;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       AccValid_i = 1'b0;
  logic       AccReady_o;
  logic [7:0] Num0_o, Num1_o, Num2_o, Num3_o, Num4_o;
  logic [7:0] Num5_o, Num6_o, Num7_o, Num8_o, Num9_o;
  scores_t    dut_num;

  int checks = 0;
  int errors = 0;

  scores_t exp_q[$];
  scores_t ref_num;
  scores_t last_num = '0;
  int      model_rem = 0;
  logic    prev_ready = 1'b1;
  int      low_cnt = 0;

  acc_core dut (
    .clk        (clk),
    .rstn       (rstn),
    .AccValid_i (AccValid_i),
    .AccReady_o (AccReady_o),
    .Num0_o     (Num0_o),
    .Num1_o     (Num1_o),
    .Num2_o     (Num2_o),
    .Num3_o     (Num3_o),
    .Num4_o     (Num4_o),
    .Num5_o     (Num5_o),
    .Num6_o     (Num6_o),
    .Num7_o     (Num7_o),
    .Num8_o     (Num8_o),
    .Num9_o     (Num9_o)
  );

  assign dut_num = {Num9_o, Num8_o, Num7_o, Num6_o, Num5_o,
                    Num4_o, Num3_o, Num2_o, Num1_o, Num0_o};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum over all 192 pixels of w(p,k)*p, plus bias, clamped.
  function automatic scores_t ref_scores();
    scores_t s;
    int      acc;
    for (int k = 0; k < 10; k++) begin
      acc = 10 * k;
      for (int p = 0; p < 192; p++) begin
        acc += (((p + k) % 3) - 1) * p;
      end
      if (acc < 0) acc = 0;
      else if (acc > 255) acc = 255;
      s[k] = acc[7:0];
    end
    return s;
  endfunction

  // Behavioural model: a request seen while idle starts a 65-cycle run.
  always @(posedge clk or posedge rstn) begin
    if (rstn) begin
      model_rem = 0;
      exp_q.delete();
    end else if (model_rem == 0) begin
      if (AccValid_i) begin
        model_rem = RunCycles;
        exp_q.push_back(ref_num);
      end
    end else begin
      model_rem--;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      check("rst_ready", 32'(AccReady_o), 32'd1);
      check("rst_num", 32'(dut_num != '0), 32'd0);
      last_num   = '0;
      prev_ready = 1'b1;
      low_cnt    = 0;
    end else begin
      check("ready", 32'(AccReady_o), 32'(model_rem == 0));
      if (!AccReady_o) low_cnt++;
      if (AccReady_o && !prev_ready) begin
        check("busy_len", 32'(low_cnt), 32'(RunCycles));
        low_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          last_num = exp_q.pop_front();
          for (int k = 0; k < 10; k++) begin
            check($sformatf("num%0d", k), 32'(dut_num[k]), 32'(last_num[k]));
          end
        end
      end else begin
        for (int k = 0; k < 10; k++) begin
          check($sformatf("hold%0d", k), 32'(dut_num[k]), 32'(last_num[k]));
        end
      end
      prev_ready = AccReady_o;
    end
  end

  task automatic pulse_valid();
    @(negedge clk);
    AccValid_i = 1'b1;
    @(negedge clk);
    AccValid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(model_rem == 0 && AccReady_o === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ref_num = ref_scores();

    // Reset, then idle with no request.
    #1 rstn = 1'b1;
    #20 rstn = 1'b0;
    repeat (18) @(negedge clk);

    // Single run.
    pulse_valid();
    wait_idle(100);
    repeat (5) @(negedge clk);

    // Extra requests at busy cycles 10 and 64 must be ignored.
    pulse_valid();
    repeat (9) @(negedge clk);
    AccValid_i = 1'b1;
    @(negedge clk);
    AccValid_i = 1'b0;
    repeat (53) @(negedge clk);
    AccValid_i = 1'b1;
    @(negedge clk);
    AccValid_i = 1'b0;
    wait_idle(100);
    repeat (10) @(negedge clk);

    // Request held high: back-to-back runs.
    AccValid_i = 1'b1;
    repeat (220) @(negedge clk);
    AccValid_i = 1'b0;
    wait_idle(100);
    repeat (3) @(negedge clk);

    // Reset in the middle of a run.
    pulse_valid();
    repeat (29) @(negedge clk);
    #3 rstn = 1'b1;
    #1;
    check("async_rst_ready", 32'(AccReady_o), 32'd1);
    check("async_rst_num", 32'(dut_num != '0), 32'd0);
    #12 rstn = 1'b0;
    repeat (10) @(negedge clk);
    pulse_valid();
    wait_idle(100);
    repeat (4) @(negedge clk);

    // Randomised requests.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      AccValid_i = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    AccValid_i = 1'b0;
    wait_idle(100);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
